// File: rtl/ecc_mod_mul.sv
// Bit-serial interleaved modular multiplier: R = A*B mod P, MSB-first scan of B.
// Field width 32/64/128/256 selected per operation; one operation in flight.
module ecc_mod_mul #(
    parameter int MAX_BITS = 256,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [MAX_BITS-1:0] i_a,
    input  logic [MAX_BITS-1:0] i_b,
    input  logic [MAX_BITS-1:0] i_prime,
    output logic                o_ready,
    output logic                o_valid,
    output logic [MAX_BITS-1:0] o_result
);
    localparam int W = MAX_BITS + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [MAX_BITS-1:0] a_q, b_q, p_q, r_q, mask;
    logic [CNT_W-1:0]    cnt;
    logic                tail;
    logic [W-1:0]        p_ext, t_dbl, t_red, t_add, t_next;

    function automatic int width_of(input logic [1:0] mode);
        int n;
        n = 32 << mode;
        return (n > MAX_BITS) ? MAX_BITS : n;
    endfunction

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_BITS; i++)
            mask[i] = (i < width_of(i_mode));
    end

    // One interleaved step: double, reduce, conditionally add a, reduce.
    always_comb begin
        p_ext  = {2'b00, p_q};
        t_dbl  = {1'b0, r_q, 1'b0};
        t_red  = (t_dbl >= p_ext) ? t_dbl - p_ext : t_dbl;
        t_add  = b_q[cnt] ? t_red + {2'b00, a_q} : t_red;
        t_next = (t_add >= p_ext) ? t_add - p_ext : t_add;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (tail) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    // After the last bit, RUN spends one more cycle copying R into the held
    // result register, giving a fixed N+1 cycle latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            r_q      <= '0;
            cnt      <= '0;
            tail     <= 1'b0;
            o_result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_q  <= i_a & mask;
                        b_q  <= i_b & mask;
                        p_q  <= i_prime & mask;
                        r_q  <= '0;
                        cnt  <= CNT_W'(width_of(i_mode) - 1);
                        tail <= 1'b0;
                    end
                end
                RUN: begin
                    if (!tail) begin
                        r_q <= t_next[MAX_BITS-1:0];
                        if (cnt == '0) tail <= 1'b1;
                        else           cnt  <= cnt - 1'b1;
                    end else begin
                        o_result <= r_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_mod_mul.sv
// Randomised and directed bench for ecc_mod_mul against a wide-arithmetic
// (a*b) % p model.
module tb_ecc_mod_mul;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [1:0]   i_mode;
    logic [255:0] i_a, i_b, i_prime;
    logic         o_ready, o_valid;
    logic [255:0] o_result;

    int passed = 0;
    int total  = 0;

    ecc_mod_mul #(.MAX_BITS(256), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode),
        .i_a(i_a), .i_b(i_b), .i_prime(i_prime),
        .o_ready(o_ready), .o_valid(o_valid), .o_result(o_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rand_wide();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] width_mask(input logic [1:0] mode);
        int n;
        n = 32 << mode;
        return (n == 256) ? {256{1'b1}} : ((256'd1 << n) - 256'd1);
    endfunction

    function automatic logic [255:0] model(input logic [1:0] mode,
                                           input logic [255:0] a, b, p);
        logic [255:0] m;
        logic [511:0] prod, pm;
        m    = width_mask(mode);
        prod = {256'b0, a & m} * {256'b0, b & m};
        pm   = {256'b0, p & m};
        return 256'(prod % pm);
    endfunction

    task automatic run_op(input string tag, input logic [1:0] mode,
                          input logic [255:0] a, b, p);
        int           n, lat;
        bit           ready_bad;
        logic [255:0] exp;
        n   = 32 << mode;
        exp = model(mode, a, b, p);
        @(negedge clk);
        check({tag, ":ready_idle"}, 256'(o_ready), 256'd1);
        i_mode = mode; i_a = a; i_b = b; i_prime = p; i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_a = rand_wide(); i_b = rand_wide(); i_prime = rand_wide();
        i_mode = 2'($urandom);
        lat = -1;
        ready_bad = 1'b0;
        for (int j = 0; j < n + 10; j++) begin
            @(negedge clk);
            if (o_valid) begin
                lat = j;
                break;
            end
            if (o_ready) ready_bad = 1'b1;
        end
        check({tag, ":latency"}, 256'(lat), 256'(n + 1));
        check({tag, ":ready_busy"}, 256'(ready_bad), 256'd0);
        check({tag, ":result"}, o_result, exp);
    endtask

    initial begin
        logic [1:0]   mode;
        logic [255:0] p, a, b, m;
        bit           seen;

        rst = 1'b0; i_start = 1'b0; i_mode = '0;
        i_a = '0; i_b = '0; i_prime = '0;
        #1;
        check("rst_ready", 256'(o_ready), 256'd1);
        check("rst_valid", 256'(o_valid), 256'd0);
        check("rst_result", o_result, 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op("m0_5x7", 2'd0, 256'd5, 256'd7, 256'd23);
        check("m0_5x7_const", o_result, 256'd12);
        @(negedge clk);
        check("hold_ready", 256'(o_ready), 256'd1);
        check("hold_valid", 256'(o_valid), 256'd0);
        check("hold_result", o_result, 256'd12);

        run_op("m0_22x22", 2'd0, 256'd22, 256'd22, 256'd23);
        check("m0_22x22_const", o_result, 256'd1);
        run_op("b2b_0x22", 2'd0, 256'd0, 256'd22, 256'd23);
        check("b2b_const", o_result, 256'd0);

        p = 256'hFFFFFFFFFFFFFFC5;
        run_op("m1_2xpm1", 2'd1, 256'd2, p - 256'd1, p);
        check("m1_const", o_result, 256'hFFFFFFFFFFFFFFC3);

        p = 256'd0 - 256'd189;
        run_op("m3_full", 2'd3, p - 256'd1, p - 256'd1, p);
        check("m3_const", o_result, 256'd1);

        run_op("mask_hi", 2'd0, 256'hFFFF_0000_0000_0005, 256'd7, 256'd23);
        check("mask_const", o_result, 256'd12);

        for (int k = 0; k < 8; k++) begin
            mode = 2'($urandom);
            m    = width_mask(mode);
            p    = (rand_wide() & m) | (256'd1 << ((32 << mode) - 1)) | 256'd1;
            a    = rand_wide() % p;
            b    = (k == 0) ? p - 256'd1 : rand_wide() % p;
            run_op($sformatf("rand%0d", k), mode, a, b, p);
        end

        // Abort a mode-2 operation with ignored start pulses along the way.
        @(negedge clk);
        i_mode = 2'd2; i_prime = rand_wide() | 256'd1;
        i_a = rand_wide(); i_b = rand_wide(); i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            i_start = (c == 5 || c == 50);
            if (c == 59) check("abort_busy", 256'(o_ready), 256'd0);
        end
        i_start = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_valid", 256'(o_valid), 256'd0);
        check("abort_ready", 256'(o_ready), 256'd1);
        check("abort_result", o_result, 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_ready", 256'(o_ready), 256'd1);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_valid || !o_ready) seen = 1'b1;
        end
        check("abort_quiet", 256'(seen), 256'd0);
        run_op("post_abort", 2'd0, 256'd5, 256'd7, 256'd23);
        check("post_abort_const", o_result, 256'd12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
